// File: rtl/fetch_pkg.sv
// fetch_pkg: shared front-end types for the fetch stage and instruction buffer.
package fetch_pkg;
  localparam int GH_DEFAULT = 8;
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetch_state_e;
  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic                  bp_pred_taken;
    logic [31:0]           bp_pred_target;
    logic [GH_DEFAULT-1:0] bp_ghr_snapshot;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding the fetch-to-decode buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          GH       = GH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          imem_req_o,
  output logic [31:0]   imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [31:0]   imem_rdata_i,
  output logic [31:0]   bp_pc_o,
  input  logic          bp_pred_taken_i,
  input  logic [31:0]   bp_pred_target_i,
  input  logic [GH-1:0] bp_ghr_i,
  input  logic          ib_full_i,
  output logic          ib_push_o,
  output logic [31:0]   ib_pc_o,
  output logic [31:0]   ib_inst_o,
  output logic          ib_pred_taken_o,
  output logic [31:0]   ib_pred_target_o,
  output logic [GH-1:0] ib_ghr_o
);
  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic         out_valid_q, grant, push;
  fetch_pkt_t   fly_q, out_q;
  // Issue only when the output register is free or drains this cycle, so a response always has a slot.
  assign imem_req_o  = !reset && !redirect_i && state_q == FETCH && (!out_valid_q || !ib_full_i);
  assign imem_addr_o = pc_q;
  assign bp_pc_o     = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign push        = out_valid_q && !ib_full_i;
  assign pc_d        = bp_pred_taken_i ? {bp_pred_target_i[31:2], 2'b00} : pc_q + 32'd4;
  assign ib_push_o        = out_valid_q;
  assign ib_pc_o          = out_q.pc;
  assign ib_inst_o        = out_q.inst;
  assign ib_pred_taken_o  = out_q.bp_pred_taken;
  assign ib_pred_target_o = out_q.bp_pred_target;
  assign ib_ghr_o         = GH'(out_q.bp_ghr_snapshot);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q        <= redirect_pc_i;
      out_valid_q <= 1'b0;
      state_q     <= (state_q == FETCH || imem_rvalid_i) ? FETCH : DRAIN;
    end else begin
      if (push) out_valid_q <= 1'b0;
      case (state_q)
        FETCH: if (grant) begin
          fly_q   <= '{pc: pc_q, inst: 32'h0, bp_pred_taken: bp_pred_taken_i,
                       bp_pred_target: bp_pred_target_i, bp_ghr_snapshot: GH_DEFAULT'(bp_ghr_i)};
          pc_q    <= pc_d;
          state_q <= WAIT;
        end
        WAIT: if (imem_rvalid_i) begin
          out_q       <= fly_q;
          out_q.inst  <= imem_rdata_i;
          out_valid_q <= 1'b1;
          state_q     <= FETCH;
        end
        default: if (imem_rvalid_i) state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] tgt;
    logic [7:0]  ghr;
  } pkt_t;
  logic        clock = 1'b0;
  logic        reset, redirect_i, imem_gnt_i, imem_rvalid_i, bp_pred_taken_i, ib_full_i;
  logic [31:0] redirect_pc_i, imem_rdata_i, bp_pred_target_i;
  logic [7:0]  bp_ghr_i;
  logic        imem_req_o, ib_push_o, ib_pred_taken_o;
  logic [31:0] imem_addr_o, bp_pc_o, ib_pc_o, ib_inst_o, ib_pred_target_o;
  logic [7:0]  ib_ghr_o;
  int          checks = 0, failures = 0;
  bit          running = 0;
  pkt_t        q[$];
  bit          inflight = 0, stale = 0, held = 0;
  logic [31:0] exp_pc = 32'h100, mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          p_gnt, p_full, p_red, p_taken, lmin, lmax;

  fetch_unit #(.GH(8), .RESET_PC(32'h100)) dut (
    .clock(clock), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .bp_pc_o(bp_pc_o),
    .bp_pred_taken_i(bp_pred_taken_i), .bp_pred_target_i(bp_pred_target_i), .bp_ghr_i(bp_ghr_i),
    .ib_full_i(ib_full_i), .ib_push_o(ib_push_o), .ib_pc_o(ib_pc_o), .ib_inst_o(ib_inst_o),
    .ib_pred_taken_o(ib_pred_taken_o), .ib_pred_target_o(ib_pred_target_o), .ib_ghr_o(ib_ghr_o)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every visible packet must equal the oldest outstanding expectation.
  always @(negedge clock) begin
    if (running && ib_push_o) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pkt_unexpected: got pc %h expected no packet", ib_pc_o);
      end else begin
        check("pkt_pc", ib_pc_o, q[0].pc);
        check("pkt_inst", ib_inst_o, q[0].inst);
        check("pkt_taken", {31'b0, ib_pred_taken_o}, {31'b0, q[0].taken});
        check("pkt_target", ib_pred_target_o, q[0].tgt);
        check("pkt_ghr", {24'b0, ib_ghr_o}, {24'b0, q[0].ghr});
        if (!ib_full_i && !redirect_i) void'(q.pop_front());
      end
    end
  end

  task automatic model_step();
    bit exp_req;
    exp_req = !redirect_i && !inflight && !stale && (!held || !ib_full_i);
    check("req", {31'b0, imem_req_o}, {31'b0, exp_req});
    check("push_valid", {31'b0, ib_push_o}, {31'b0, held});
    if (exp_req) begin
      check("imem_addr", imem_addr_o, exp_pc);
      check("bp_pc", bp_pc_o, exp_pc);
    end
    if (redirect_i) begin
      q.delete();
      held = 0;
      stale = (inflight || stale) && !imem_rvalid_i;
      inflight = 0;
      exp_pc = redirect_pc_i;
    end else begin
      if (held && !ib_full_i) held = 0;
      if (imem_rvalid_i) begin
        if (inflight) begin
          inflight = 0;
          held = 1;
        end else stale = 0;
      end
      if (exp_req && imem_gnt_i) begin
        q.push_back('{pc: exp_pc, inst: mem_word(exp_pc), taken: bp_pred_taken_i,
                      tgt: bp_pred_target_i, ghr: bp_ghr_i});
        inflight = 1;
        exp_pc = bp_pred_taken_i ? (bp_pred_target_i & 32'hffff_fffc) : exp_pc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n, input int gnt, input int full, input int red, input int tk,
                     input int lo, input int hi);
    p_gnt = gnt; p_full = full; p_red = red; p_taken = tk; lmin = lo; lmax = hi;
    for (int c = 0; c < n; c++) begin
      imem_gnt_i       = $urandom_range(99) < p_gnt;
      ib_full_i        = $urandom_range(99) < p_full;
      redirect_i       = $urandom_range(99) < p_red;
      redirect_pc_i    = $urandom & 32'hffff_fffc;
      bp_pred_taken_i  = $urandom_range(99) < p_taken;
      bp_pred_target_i = $urandom;
      bp_ghr_i         = 8'($urandom);
      imem_rvalid_i    = mem_cnt == 1;
      imem_rdata_i     = imem_rvalid_i ? mem_word(mem_addr) : $urandom;
      @(negedge clock);
      #1;
      model_step();
      if (mem_cnt > 0) mem_cnt--;
      if (imem_req_o && imem_gnt_i) begin
        mem_cnt  = $urandom_range(lmax, lmin);
        mem_addr = imem_addr_o;
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1; redirect_i = 0; redirect_pc_i = 0; imem_gnt_i = 1; imem_rvalid_i = 0;
    imem_rdata_i = 0; bp_pred_taken_i = 0; bp_pred_target_i = 0; bp_ghr_i = 0; ib_full_i = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_req", {31'b0, imem_req_o}, 32'd0);
    check("reset_push", {31'b0, ib_push_o}, 32'd0);
    @(posedge clock);
    #1;
    reset = 0;
    running = 1;
    run(30, 100, 0, 0, 0, 1, 1);
    run(40, 100, 0, 0, 50, 1, 1);
    run(300, 70, 60, 0, 30, 1, 3);
    run(2000, 60, 40, 10, 30, 1, 3);
    run(600, 80, 50, 30, 20, 1, 2);
    run(40, 100, 0, 0, 0, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
